vram_scan_arbiter: RTL

- Shares one single-port tile RAM between the VGA scan-out path and the game-logic writer.
- Scan-out owns the RAM whenever `visible` is high. In each cycle it reads the tile code of the 32x32-pixel cell under the beam.
- Game-logic writes are queued in a small FIFO and drained only during blanking.
- A board-clear command sweeps the whole RAM during blanking, resuming across frames until done.
- Sits between the 800x600 VGA timing generator, the tile RAM and the pixel colour mapper.

---
 rtl/vga_pkg.sv | 50 +++++
 rtl/vram_scan_arbiter_if.sv | 18 +
 rtl/vram_scan_arbiter_wr_fifo.sv | 59 +++++
 rtl/vram_scan_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the 800x600 VGA tile-map path: grid geometry,
// video timing, arbiter state encoding and the cell-address helper.
package vga_pkg;

  // Tile grid: 32x32-pixel cells over an 800x600 raster.
  localparam int CELL_SHIFT = 5;
  localparam int GRID_COLS  = 25;
  localparam int GRID_ROWS  = 19;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 4;
  localparam int CELL_COUNT = GRID_COLS * GRID_ROWS;

  // 800x600 @ 72 Hz timing on a 50 MHz pixel clock.
  localparam int H_VISIBLE = 800;
  localparam int H_FRONT   = 56;
  localparam int H_SYNC    = 120;
  localparam int H_BACK    = 64;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = 600;
  localparam int V_FRONT   = 37;
  localparam int V_SYNC    = 6;
  localparam int V_BACK    = 23;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Owner of the RAM port for the command issued this cycle.
  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    CLEAR = 2'd1,
    DRAIN = 2'd2,
    IDLE  = 2'd3
  } arb_state_t;

  // One queued game-logic write.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  // Cell index under the beam; the multiply deliberately truncates to
  // ADDR_W bits, which is exact for every visible coordinate.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [10:0] row,
                                                  input logic [11:0] col);
    logic [ADDR_W-1:0] cell_row;
    logic [ADDR_W-1:0] cell_col;
    cell_row = ADDR_W'(row >> CELL_SHIFT);
    cell_col = ADDR_W'(col >> CELL_SHIFT);
    return (cell_row * ADDR_W'(GRID_COLS)) + cell_col;
  endfunction

endpackage

// File: rtl/vram_scan_arbiter_if.sv
// Game-logic write port into the tile RAM arbiter (valid/ready handshake).
interface vram_scan_arbiter_if;
  import vga_pkg::*;

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  // Game logic drives requests and waits for ready.
  modport master (output wr_valid, output wr_addr, output wr_data,
                  input  wr_ready);

  // Arbiter accepts requests and reports queue space.
  modport slave  (input  wr_valid, input  wr_addr, input  wr_data,
                  output wr_ready);

endinterface

// File: rtl/vram_scan_arbiter_wr_fifo.sv
// Small synchronous FIFO with first-word fall-through output. Full and
// empty come straight from the registered occupancy count.
module wr_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
  // pointers wrap naturally.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clock) begin
    // NOTE: storage is deliberately not reset; the pointers alone define
    // which entries are valid, so a reset storage array would be wasted logic.
    if (push_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vram_scan_arbiter.sv
// Arbitrates the single-port tile RAM between beam scan-out (owns the port
// during active video) and blanking-time work: the board-clear sweep first,
// then queued game-logic writes. Also forms the 3-stage pixel path.
module vram_scan_arbiter
  import vga_pkg::*;
#(
  parameter int                FIFO_DEPTH  = 4,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [11:0]         display_col,
  input  logic [10:0]         display_row,
  input  logic                visible,
  vram_scan_arbiter_if.slave  wr,
  input  logic                clr_start,
  output logic                clr_busy,
  output logic                wr_err,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [DATA_W-1:0]   pix_data,
  output logic                pix_valid
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELL_COUNT - 1);

  arb_state_t        mode;
  wr_entry_t         fifo_din;
  wr_entry_t         fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [ADDR_W-1:0] clr_ptr;
  logic [2:0]        vis_pipe;

  assign wr.wr_ready = !fifo_full;
  assign fifo_push   = wr.wr_valid && wr.wr_ready;
  assign fifo_din    = {wr.wr_addr, wr.wr_data};
  assign fifo_pop    = (mode == DRAIN);

  wr_fifo #(
    .WIDTH ($bits(wr_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Per-cycle ownership decision: scan-out whenever the beam is visible,
  // otherwise clear beats drain.
  always_comb begin
    // NOTE: default first so every path assigns mode and no latch appears.
    mode = IDLE;
    if (visible)          mode = SCAN;
    else if (clr_busy)    mode = CLEAR;
    else if (!fifo_empty) mode = DRAIN;
  end

  // Arbiter FSM: registers the RAM command and the clear/error state.
  always_ff @(posedge clock) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      clr_busy  <= 1'b0;
      clr_ptr   <= '0;
      wr_err    <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      case (mode)
        SCAN: begin
          ram_addr <= cell_addr(display_row, display_col);
        end
        CLEAR: begin
          ram_addr  <= clr_ptr;
          ram_wdata <= CLEAR_VALUE;
          ram_we    <= 1'b1;
          if (clr_ptr == LAST_CELL) begin
            clr_busy <= 1'b0;
            clr_ptr  <= '0;
          end else begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          ram_addr  <= fifo_dout.addr;
          ram_wdata <= fifo_dout.data;
          if (fifo_dout.addr < ADDR_W'(CELL_COUNT)) ram_we <= 1'b1;
          else                                      wr_err <= 1'b1;
        end
        default: ;  // IDLE: port quiet, address held
      endcase
      // A new clear is armed only from blanking and only when none is running.
      if (!visible && !clr_busy && clr_start) begin
        clr_busy <= 1'b1;
        clr_ptr  <= '0;
      end
    end
  end

  // Pixel path: RAM data registered once more; visible delayed to match.
  always_ff @(posedge clock) begin
    if (reset) begin
      vis_pipe <= '0;
      pix_data <= '0;
    end else begin
      vis_pipe <= {vis_pipe[1:0], visible};
      pix_data <= ram_rdata;
    end
  end

  assign pix_valid = vis_pipe[2];

endmodule
